packer_flex: RTL and testbench



---
 rtl/packer_pkg.sv | 20 ++
 rtl/counter_roll.sv | 23 ++
 rtl/elastic.sv | 33 +++
 rtl/packer_flex.sv | 87 ++++++++
 tb/tb_packer_flex.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/packer_pkg.sv
// Shared lane-ordering helpers for the packer family.
// Used by packer_flex and the planned unpacker.
package packer_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } lane_order_e;

  function automatic int lane_lsb(
    input int          k,
    input int          width,
    input int          ratio,
    input lane_order_e order
  );
    if (order == MSB_FIRST) return (ratio - 1 - k) * width;
    return k * width;
  endfunction

endpackage

// File: rtl/counter_roll.sv
// Rolling up-counter 0..max_val_p with synchronous clear.
// Clear has priority over count-up.
module counter_roll #(
  parameter int max_val_p = 3,
  parameter int width_lp  = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_o <= '0;
    end else if (up_i) begin
      if (count_o == width_lp'(max_val_p)) count_o <= '0;
      else count_o <= count_o + width_lp'(1);
    end
  end

endmodule

// File: rtl/elastic.sv
// One-entry valid/ready register stage.
// Accepts a new entry in the same cycle the old one drains.
module elastic #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  logic load;

  assign ready_o = !valid_o || ready_i;
  assign load    = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/packer_flex.sv
// Packs ratio_p lanes of width_p bits into one word,
// with last_i flush of zero-padded partial words.
module packer_flex
  import packer_pkg::*;
#(
  parameter int width_p     = 2,
  parameter int ratio_p     = 4,
  parameter int msb_first_p = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [width_p-1:0]           unpacked_i,
  input  logic                         last_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [width_p*ratio_p-1:0]   packed_o,
  output logic [$clog2(ratio_p+1)-1:0] count_o,
  output logic                         last_o,
  output logic                         valid_o,
  input  logic                         ready_i
);

  localparam int W  = width_p * ratio_p;
  localparam int CW = $clog2(ratio_p + 1);
  localparam int IW = $clog2(ratio_p);
  localparam int EW = W + CW + 1;
  localparam lane_order_e ORDER =
    (msb_first_p != 0) ? MSB_FIRST : LSB_FIRST;

  logic [IW-1:0] idx;
  logic [W-1:0]  acc_r;
  logic [W-1:0]  lane;
  logic [W-1:0]  word;
  logic [CW-1:0] count_d;
  logic [EW-1:0] stage_d;
  logic [EW-1:0] stage_q;
  logic          closing;
  logic          accept;
  logic          stage_ready;

  // Only a closing beat needs room in the output stage.
  assign closing = valid_i && ((idx == IW'(ratio_p - 1)) || last_i);
  assign ready_o = !closing || stage_ready;
  assign accept  = valid_i && ready_o;

  assign lane    = W'(unpacked_i)
                   << lane_lsb(int'(idx), width_p, ratio_p, ORDER);
  assign word    = acc_r | lane;
  assign count_d = CW'(idx) + CW'(1);
  assign stage_d = {word, count_d, last_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_r <= '0;
    end else if (accept) begin
      acc_r <= closing ? '0 : word;
    end
  end

  counter_roll #(
    .max_val_p(ratio_p - 1)
  ) idx_ctr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(accept && closing),
    .up_i   (accept),
    .count_o(idx)
  );

  elastic #(
    .width_p(EW)
  ) out_stage (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (stage_d),
    .valid_i(accept && closing),
    .ready_o(stage_ready),
    .data_o (stage_q),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  assign packed_o = stage_q[EW-1 -: W];
  assign count_o  = stage_q[CW:1];
  assign last_o   = stage_q[0];

endmodule

// File: tb/tb_packer_flex.sv
// Scoreboard bench for packer_flex: LSB-first and MSB-first
// instances share stimulus; monitors check every output handshake.
module tb_packer_flex;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [1:0] unpacked_i;
  logic       last_i;
  logic       valid_i;
  logic       ready_i;

  logic       ready0, ready1;
  logic [7:0] packed0, packed1;
  logic [2:0] count0, count1;
  logic       last0, last1;
  logic       valid0, valid1;

  typedef struct {
    logic [7:0] p;
    logic [2:0] c;
    logic       l;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  packer_flex #(.width_p(2), .ratio_p(4), .msb_first_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .unpacked_i(unpacked_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(ready0),
    .packed_o(packed0), .count_o(count0), .last_o(last0),
    .valid_o(valid0), .ready_i(ready_i)
  );

  packer_flex #(.width_p(2), .ratio_p(4), .msb_first_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .unpacked_i(unpacked_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(ready1),
    .packed_o(packed1), .count_o(count1), .last_o(last1),
    .valid_o(valid1), .ready_i(ready_i)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_word(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [2:0] c, input logic l);
    exp_t e0, e1;
    e0.p = p0; e0.c = c; e0.l = l;
    e1.p = p1; e1.c = c; e1.l = l;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  always @(negedge clk) begin
    if (!reset_i && valid0 && ready_i) begin
      if (q0.size() == 0) begin
        chk("lsb_unexpected_word", {24'd0, packed0}, 32'hFFFF);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("lsb_packed", {24'd0, packed0}, {24'd0, e.p});
        chk("lsb_count", {29'd0, count0}, {29'd0, e.c});
        chk("lsb_last", {31'd0, last0}, {31'd0, e.l});
      end
    end
    if (!reset_i && valid1 && ready_i) begin
      if (q1.size() == 0) begin
        chk("msb_unexpected_word", {24'd0, packed1}, 32'hFFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("msb_packed", {24'd0, packed1}, {24'd0, e.p});
        chk("msb_count", {29'd0, count1}, {29'd0, e.c});
        chk("msb_last", {31'd0, last1}, {31'd0, e.l});
      end
    end
  end

  task automatic beat(input logic [1:0] d, input logic l);
    unpacked_i = d;
    last_i     = l;
    valid_i    = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready0) begin
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        return;
      end
    end
    chk("beat_timeout", 32'd0, 32'd1);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; unpacked_i = '0; last_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1;
    idle(2);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_packed", {24'd0, packed0}, 32'd0);
    chk("rst_count", {29'd0, count0}, 32'd0);
    chk("rst_last", {31'd0, last0}, 32'd0);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_valid_msb", {31'd0, valid1}, 32'd0);
    reset_i = 1'b0;
    idle(1);

    // full word, checked for one-cycle latency
    expect_word(8'h39, 8'h6C, 3'd4, 1'b0);
    beat(2'd1, 1'b0); beat(2'd2, 1'b0); beat(2'd3, 1'b0);
    chk("no_early_valid", {31'd0, valid0}, 32'd0);
    beat(2'd0, 1'b0);
    chk("latency_valid", {31'd0, valid0}, 32'd1);
    idle(1);

    // partial flush, then next word from lane 0
    expect_word(8'h07, 8'hD0, 3'd2, 1'b1);
    beat(2'd3, 1'b0); beat(2'd1, 1'b1);
    expect_word(8'h02, 8'h80, 3'd1, 1'b1);
    beat(2'd2, 1'b1);
    expect_word(8'hE4, 8'h1B, 3'd4, 1'b1);
    beat(2'd0, 1'b0); beat(2'd1, 1'b0);
    beat(2'd2, 1'b0); beat(2'd3, 1'b1);
    idle(2);

    // backpressure: only the closing beat stalls
    ready_i = 1'b0;
    expect_word(8'h39, 8'h6C, 3'd4, 1'b0);
    beat(2'd1, 1'b0); beat(2'd2, 1'b0);
    beat(2'd3, 1'b0); beat(2'd0, 1'b0);
    c0 = cyc;
    beat(2'd1, 1'b0); beat(2'd2, 1'b0); beat(2'd3, 1'b0);
    chk("bp_lanes_accepted", cyc - c0, 32'd3);
    expect_word(8'h39, 8'h6C, 3'd4, 1'b0);
    unpacked_i = 2'd0; valid_i = 1'b1;
    @(negedge clk);
    chk("bp_stall_ready", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    chk("bp_hold_packed", {24'd0, packed0}, 32'h39);
    chk("bp_hold_valid", {31'd0, valid0}, 32'd1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, ready0}, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", {31'd0, valid0}, 32'd1);
    chk("bp_new_ready", {31'd0, ready0}, 32'd1);
    idle(2);

    // back-to-back words without bubbles
    expect_word(8'h39, 8'h6C, 3'd4, 1'b0);
    expect_word(8'h39, 8'h6C, 3'd4, 1'b0);
    c0 = cyc;
    for (int k = 0; k < 8; k++) beat(2'((k + 1) % 4), 1'b0);
    chk("b2b_cycles", cyc - c0, 32'd8);
    idle(3);

    // reset drops a pending word and a partial word
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) beat(2'd3, 1'b0);
    beat(2'd1, 1'b0); beat(2'd2, 1'b0);
    reset_i = 1'b1;
    idle(1);
    chk("rst_mid_valid", {31'd0, valid0}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready0}, 32'd1);
    reset_i = 1'b0;
    ready_i = 1'b1;
    expect_word(8'h40, 8'h01, 3'd4, 1'b0);
    beat(2'd0, 1'b0); beat(2'd0, 1'b0);
    beat(2'd0, 1'b0); beat(2'd1, 1'b0);
    idle(4);

    // a stray last_i without valid_i must not emit anything
    last_i = 1'b1;
    @(negedge clk);
    chk("stray_last_valid", {31'd0, valid0}, 32'd0);
    last_i = 1'b0;
    idle(2);

    chk("lsb_queue_empty", q0.size(), 32'd0);
    chk("msb_queue_empty", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
